// File: rtl/dircc_system_states_pkg.sv
// dircc_system_states_pkg: system-wide constants shared with the device-state memory map
//   no ports; DEVICE_STATE_STRIDE is the byte distance between consecutive device records
package dircc_system_states_pkg;
    localparam int DEVICE_STATE_STRIDE = 16;
endpackage

// File: rtl/dircc_types_pkg.sv
// dircc_types_pkg: shared scheduler types
//   no ports; rts_sched_state_t is the RTS scheduler FSM, send_request_t a (device, port) send request
package dircc_types_pkg;
    localparam int SEND_DEV_BITS = 16;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVAL, SEND} rts_sched_state_t;
    typedef struct packed {
        logic [SEND_DEV_BITS-1:0] dev;
        logic [4:0]               port;
    } send_request_t;
endpackage

// File: rtl/dircc_priority_encoder32.sv
// dircc_priority_encoder32: index of the lowest set bit of a 32-bit mask
//   mask  : input mask
//   port  : index of the lowest set bit (0 when mask is zero)
//   valid : mask has at least one bit set
module dircc_priority_encoder32 (
    input  logic [31:0] mask,
    output logic [4:0]  port,
    output logic        valid
);
    always_comb begin
        port = '0;
        for (int i = 31; i >= 0; i--) port = mask[i] ? 5'(i) : port;
    end
    assign valid = |mask;
endmodule

// File: rtl/dircc_rts_scheduler.sv
// dircc_rts_scheduler: round-robin RTS scheduler over the devices hosted on one processing element
//   clk, reset_n           : clock, asynchronous active-low reset
//   enable                 : scanning allowed (system RUNNING)
//   state_addr, state_rd   : device-state read address and its one-cycle strobe
//   rts_ready              : port-ready mask, valid RTS_LATENCY cycles after state_rd
//   send_req/dev/port/ack  : request handshake with the send engine
//   sweep_empty            : pulse after NUM_DEVICES consecutive empty evaluations
//   cur_dev                : device currently being scanned
module dircc_rts_scheduler
    import dircc_types_pkg::*;
    import dircc_system_states_pkg::*;
#(
    parameter int                           NUM_DEVICES       = 16,
    parameter int                           ADDRESS_MEM_WIDTH = 32,
    parameter logic [ADDRESS_MEM_WIDTH-1:0] STATE_BASE_ADDR   = '0,
    parameter int                           STATE_STRIDE      = DEVICE_STATE_STRIDE,
    parameter int                           RTS_LATENCY       = 2,
    parameter int                           DEV_IDX_WIDTH     = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    output logic [ADDRESS_MEM_WIDTH-1:0] state_addr,
    output logic                         state_rd,
    input  logic [31:0]                  rts_ready,
    output logic                         send_req,
    output logic [DEV_IDX_WIDTH-1:0]     send_dev,
    output logic [4:0]                   send_port,
    input  logic                         send_ack,
    output logic                         sweep_empty,
    output logic [DEV_IDX_WIDTH-1:0]     cur_dev
);
    localparam int CNT_W   = $clog2(RTS_LATENCY + 1);
    localparam int EMPTY_W = $clog2(NUM_DEVICES + 1);
    localparam logic [DEV_IDX_WIDTH-1:0] LAST_DEV   = DEV_IDX_WIDTH'(NUM_DEVICES - 1);
    localparam logic [CNT_W-1:0]         WAIT_LOAD  = CNT_W'(RTS_LATENCY - 1);
    localparam logic [EMPTY_W-1:0]       LAST_EMPTY = EMPTY_W'(NUM_DEVICES - 1);

    rts_sched_state_t               state, state_n;
    logic [DEV_IDX_WIDTH-1:0]       dev_idx, dev_n, dev_next, sdev_n;
    logic [CNT_W-1:0]               cnt, cnt_n;
    logic [EMPTY_W-1:0]             empty_cnt, empty_n;
    logic [ADDRESS_MEM_WIDTH-1:0]   addr_n;
    logic [4:0]                     sport_n, enc_port;
    logic                           req_n, sweep_n, enc_valid;

    dircc_priority_encoder32 u_enc (.mask(rts_ready), .port(enc_port), .valid(enc_valid));

    assign dev_next = (dev_idx == LAST_DEV) ? '0 : dev_idx + DEV_IDX_WIDTH'(1);
    assign state_rd = (state == ISSUE);
    assign cur_dev  = dev_idx;
    // The address is latched on entry to ISSUE so it is valid with state_rd and stays put until the next device.
    assign addr_n   = (state_n == ISSUE)
                    ? STATE_BASE_ADDR + ADDRESS_MEM_WIDTH'(dev_n) * ADDRESS_MEM_WIDTH'(STATE_STRIDE)
                    : state_addr;

    always_comb begin
        state_n   = state;
        dev_n     = dev_idx;
        cnt_n     = cnt;
        empty_n   = empty_cnt;
        req_n     = send_req;
        sdev_n    = send_dev;
        sport_n   = send_port;
        sweep_n   = 1'b0;
        case (state)
            IDLE: state_n = enable ? ISSUE : IDLE;
            ISSUE: begin
                cnt_n   = WAIT_LOAD;
                state_n = (RTS_LATENCY > 1) ? WAIT : EVAL;
            end
            WAIT: begin
                cnt_n   = cnt - CNT_W'(1);
                state_n = (cnt == CNT_W'(1)) ? EVAL : WAIT;
            end
            EVAL: begin
                if (enc_valid) begin
                    req_n   = 1'b1;
                    sdev_n  = dev_idx;
                    sport_n = enc_port;
                    empty_n = '0;
                    state_n = SEND;
                end else begin
                    sweep_n = (empty_cnt == LAST_EMPTY);
                    // Going idle also restarts the pass, so a sweep needs an uninterrupted run.
                    empty_n = (sweep_n || !enable) ? '0 : empty_cnt + EMPTY_W'(1);
                    dev_n   = dev_next;
                    state_n = enable ? ISSUE : IDLE;
                end
            end
            SEND: begin
                if (send_ack) begin
                    req_n   = 1'b0;
                    dev_n   = dev_next;
                    state_n = enable ? ISSUE : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            dev_idx     <= '0;
            cnt         <= '0;
            empty_cnt   <= '0;
            state_addr  <= '0;
            send_req    <= 1'b0;
            send_dev    <= '0;
            send_port   <= '0;
            sweep_empty <= 1'b0;
        end else begin
            state       <= state_n;
            dev_idx     <= dev_n;
            cnt         <= cnt_n;
            empty_cnt   <= empty_n;
            state_addr  <= addr_n;
            send_req    <= req_n;
            send_dev    <= sdev_n;
            send_port   <= sport_n;
            sweep_empty <= sweep_n;
        end
    end
endmodule

// File: tb/tb_dircc_rts_scheduler.sv
// tb_dircc_rts_scheduler: self-checking bench for dircc_rts_scheduler (4 devices, latency 2)
module tb_dircc_rts_scheduler;
    import dircc_types_pkg::*;
    localparam int N = 4, AW = 32, STRIDE = 16, LAT = 2, DW = 2;
    localparam logic [AW-1:0] BASE = '0;

    logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, send_ack = 1'b0;
    logic [31:0] rts_ready = '0;
    logic [AW-1:0] state_addr;
    logic state_rd, send_req, sweep_empty;
    logic [DW-1:0] send_dev, cur_dev;
    logic [4:0] send_port;

    int checks = 0, errors = 0, cyc = 0;
    logic [31:0] mask_tbl [N];
    bit rand_mode = 1'b0;
    int rd_cnt = 0;
    logic [31:0] last_rd_mask = '0;
    bit pend = 1'b0;
    int pend_due = 0;
    logic [31:0] pend_mask = '0;

    dircc_rts_scheduler #(
        .NUM_DEVICES(N), .ADDRESS_MEM_WIDTH(AW), .STATE_BASE_ADDR(BASE),
        .STATE_STRIDE(STRIDE), .RTS_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .state_addr(state_addr),
        .state_rd(state_rd), .rts_ready(rts_ready), .send_req(send_req),
        .send_dev(send_dev), .send_port(send_port), .send_ack(send_ack),
        .sweep_empty(sweep_empty), .cur_dev(cur_dev)
    );

    always #5 clk = ~clk;

    function automatic int dev_of(logic [AW-1:0] a);
        return int'(((a - BASE) / STRIDE) % N);
    endfunction

    function automatic logic [AW-1:0] addr_of(int d);
        return BASE + AW'(d * STRIDE);
    endfunction

    function automatic int low_port(logic [31:0] m);
        logic [31:0] iso;
        int p;
        iso = m & (~m + 32'd1);
        p = -1;
        for (int i = 0; i < 32; i++) if (iso == (32'd1 << i)) p = i;
        return p;
    endfunction

    function automatic logic [31:0] pick_mask();
        int r;
        r = int'($urandom_range(0, 3));
        if (r < 2) return '0;
        if (r == 2) return 32'd1 << $urandom_range(0, 31);
        return $urandom;
    endfunction

    // Memory/handler model: answers each read with the device's mask exactly LAT cycles later, noise otherwise.
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        rts_ready = $urandom;
        if (!reset_n) pend = 1'b0;
        else begin
            if (pend && cyc == pend_due) begin
                rts_ready = pend_mask;
                pend = 1'b0;
            end
            if (state_rd) begin
                pend_mask = rand_mode ? pick_mask() : mask_tbl[dev_of(state_addr)];
                pend = 1'b1;
                pend_due = cyc + LAT;
                rd_cnt++;
                last_rd_mask = pend_mask;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        enable = 1'b0;
        send_ack = 1'b0;
        rand_mode = 1'b0;
        reset_n = 1'b0;
        for (int d = 0; d < N; d++) mask_tbl[d] = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < N; d++) mask_tbl[d] = '0;
        @(negedge clk);
        checks++;
        if ({state_addr, state_rd, send_req, send_dev, send_port, sweep_empty, cur_dev} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%0h rd=%b req=%b dev=%0d port=%0d sweep=%b cur=%0d expected all 0",
                     state_addr, state_rd, send_req, send_dev, send_port, sweep_empty, cur_dev);
        end
        enable = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (state_rd !== 1'b0) begin errors++; $display("FAIL reset_hold_rd: got %b expected 0", state_rd); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({state_rd, state_addr} !== {1'b1, addr_of(0)}) begin
            errors++;
            $display("FAIL reset_first_issue: got rd=%b addr=%0h expected rd=1 addr=%0h", state_rd, state_addr, addr_of(0));
        end
        enable = 1'b0;
    endtask

    task automatic test_empty_sweep();
        logic [AW-1:0] addrs[$];
        int rcyc[$];
        int sweeps = 0, sweep_cyc = -1;
        bit any_req = 1'b0;
        do_reset();
        enable = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (state_rd) begin addrs.push_back(state_addr); rcyc.push_back(cyc); end
            if (sweep_empty) begin sweeps++; sweep_cyc = cyc; end
            any_req |= send_req;
        end
        enable = 1'b0;
        checks++;
        if (addrs.size() != 5) begin errors++; $display("FAIL sweep_read_count: got %0d expected 5", addrs.size()); end
        for (int i = 0; i < addrs.size() && i < 5; i++) begin
            checks++;
            if (addrs[i] !== addr_of(i % N)) begin
                errors++;
                $display("FAIL sweep_addr[%0d]: got %0h expected %0h", i, addrs[i], addr_of(i % N));
            end
        end
        for (int i = 1; i < rcyc.size() && i < 5; i++) begin
            checks++;
            if (rcyc[i] - rcyc[i-1] != LAT + 1) begin
                errors++;
                $display("FAIL sweep_rd_spacing[%0d]: got %0d expected %0d", i, rcyc[i] - rcyc[i-1], LAT + 1);
            end
        end
        checks++;
        if (sweeps != 1) begin errors++; $display("FAIL sweep_pulse_count: got %0d expected 1", sweeps); end
        if (rcyc.size() >= 4) begin
            checks++;
            if (sweep_cyc != rcyc[3] + LAT + 1) begin
                errors++;
                $display("FAIL sweep_pulse_time: got cycle %0d expected %0d", sweep_cyc, rcyc[3] + LAT + 1);
            end
        end
        checks++;
        if (any_req !== 1'b0) begin errors++; $display("FAIL sweep_no_req: got send_req=1 expected 0"); end
    endtask

    task automatic test_send_hold();
        int n = 0;
        do_reset();
        mask_tbl[2] = 32'h0000_0014;
        enable = 1'b1;
        while (!send_req && n < 40) begin @(negedge clk); n++; end
        checks++;
        if ({send_req, send_dev, send_port} !== {1'b1, 2'd2, 5'd2}) begin
            errors++;
            $display("FAIL hold_grant: got req=%b dev=%0d port=%0d expected req=1 dev=2 port=2", send_req, send_dev, send_port);
        end
        mask_tbl[2] = '0;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({send_req, send_dev, send_port, state_rd} !== {1'b1, 2'd2, 5'd2, 1'b0}) begin
                errors++;
                $display("FAIL hold_stable: got req=%b dev=%0d port=%0d rd=%b expected req=1 dev=2 port=2 rd=0",
                         send_req, send_dev, send_port, state_rd);
            end
        end
        send_ack = 1'b1;
        @(negedge clk);
        send_ack = 1'b0;
        checks++;
        if ({send_req, state_rd, state_addr, cur_dev} !== {1'b0, 1'b1, addr_of(3), 2'd3}) begin
            errors++;
            $display("FAIL hold_after_ack: got req=%b rd=%b addr=%0h cur=%0d expected req=0 rd=1 addr=%0h cur=3",
                     send_req, state_rd, state_addr, cur_dev, addr_of(3));
        end
        enable = 1'b0;
    endtask

    task automatic test_fairness();
        send_request_t grants[$];
        send_request_t g;
        int reads[$];
        bit swept = 1'b0;
        int n = 0;
        do_reset();
        mask_tbl[1] = 32'h1;
        mask_tbl[2] = 32'h1;
        enable = 1'b1;
        while ((grants.size() < 4 || reads.size() < 8) && n < 200) begin
            @(negedge clk);
            n++;
            send_ack = 1'b0;
            if (state_rd) reads.push_back(dev_of(state_addr));
            if (sweep_empty) swept = 1'b1;
            if (send_req) begin
                g.dev = SEND_DEV_BITS'(send_dev);
                g.port = send_port;
                grants.push_back(g);
                send_ack = 1'b1;
            end
        end
        @(negedge clk);
        send_ack = 1'b0;
        enable = 1'b0;
        checks++;
        if (n >= 200) begin errors++; $display("FAIL fair_timeout: got %0d grants %0d reads expected 4 and 8", grants.size(), reads.size()); end
        for (int i = 0; i < grants.size() && i < 4; i++) begin
            checks++;
            if (grants[i].dev != SEND_DEV_BITS'((i % 2) + 1) || grants[i].port != 5'd0) begin
                errors++;
                $display("FAIL fair_grant[%0d]: got dev=%0d port=%0d expected dev=%0d port=0", i, grants[i].dev, grants[i].port, (i % 2) + 1);
            end
        end
        for (int i = 0; i < reads.size() && i < 8; i++) begin
            checks++;
            if (reads[i] != i % N) begin errors++; $display("FAIL fair_read[%0d]: got dev %0d expected %0d", i, reads[i], i % N); end
        end
        checks++;
        if (swept !== 1'b0) begin errors++; $display("FAIL fair_no_sweep: got sweep_empty pulse expected none"); end
    endtask

    task automatic test_enable_drop();
        int n = 0, rds = 0, reqs = 0;
        do_reset();
        mask_tbl[1] = 32'h1;
        enable = 1'b1;
        while (!send_req && n < 40) begin @(negedge clk); n++; end
        checks++;
        if ({send_req, send_dev} !== {1'b1, 2'd1}) begin
            errors++;
            $display("FAIL drop_grant: got req=%b dev=%0d expected req=1 dev=1", send_req, send_dev);
        end
        enable = 1'b0;
        mask_tbl[1] = '0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({send_req, send_dev} !== {1'b1, 2'd1}) begin
                errors++;
                $display("FAIL drop_req_held: got req=%b dev=%0d expected req=1 dev=1", send_req, send_dev);
            end
        end
        send_ack = 1'b1;
        @(negedge clk);
        send_ack = 1'b0;
        repeat (10) begin
            @(negedge clk);
            rds += int'(state_rd);
            reqs += int'(send_req);
        end
        checks++;
        if (rds != 0 || reqs != 0) begin
            errors++;
            $display("FAIL drop_idle: got %0d reads %0d req cycles expected 0 and 0", rds, reqs);
        end
        enable = 1'b1;
        n = 0;
        while (!state_rd && n < 10) begin @(negedge clk); n++; end
        checks++;
        if ({state_rd, state_addr} !== {1'b1, addr_of(2)}) begin
            errors++;
            $display("FAIL drop_resume: got rd=%b addr=%0h expected rd=1 addr=%0h", state_rd, state_addr, addr_of(2));
        end
        enable = 1'b0;
    endtask

    task automatic test_async_reset();
        int n = 0, r = 0;
        do_reset();
        enable = 1'b1;
        while (r < 3 && n < 30) begin @(negedge clk); n++; if (state_rd) r++; end
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({send_req, state_rd, sweep_empty, state_addr, cur_dev} !== '0) begin
            errors++;
            $display("FAIL areset_wait: got req=%b rd=%b sweep=%b addr=%0h cur=%0d expected all 0",
                     send_req, state_rd, sweep_empty, state_addr, cur_dev);
        end
        @(negedge clk);
        reset_n = 1'b1;
        mask_tbl[1] = 32'h1;
        n = 0;
        while (!state_rd && n < 10) begin @(negedge clk); n++; end
        checks++;
        if ({state_rd, state_addr} !== {1'b1, addr_of(0)}) begin
            errors++;
            $display("FAIL areset_wait_restart: got rd=%b addr=%0h expected rd=1 addr=%0h", state_rd, state_addr, addr_of(0));
        end
        n = 0;
        while (!send_req && n < 40) begin @(negedge clk); n++; end
        @(posedge clk);
        #2;
        checks++;
        if (send_req !== 1'b1) begin errors++; $display("FAIL areset_send_pending: got req=%b expected 1", send_req); end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({send_req, state_rd, sweep_empty, send_dev} !== '0) begin
            errors++;
            $display("FAIL areset_send: got req=%b rd=%b sweep=%b dev=%0d expected all 0", send_req, state_rd, sweep_empty, send_dev);
        end
        mask_tbl[1] = '0;
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        while (!state_rd && n < 10) begin @(negedge clk); n++; end
        checks++;
        if ({state_rd, state_addr, send_req} !== {1'b1, addr_of(0), 1'b0}) begin
            errors++;
            $display("FAIL areset_send_restart: got rd=%b addr=%0h req=%b expected rd=1 addr=%0h req=0",
                     state_rd, state_addr, send_req, addr_of(0));
        end
        enable = 1'b0;
    endtask

    task automatic test_port_edges();
        int n = 0;
        do_reset();
        mask_tbl[0] = 32'h8000_0000;
        enable = 1'b1;
        while (!send_req && n < 40) begin @(negedge clk); n++; end
        checks++;
        if ({send_req, send_dev, send_port} !== {1'b1, 2'd0, 5'd31}) begin
            errors++;
            $display("FAIL port_msb: got req=%b dev=%0d port=%0d expected req=1 dev=0 port=31", send_req, send_dev, send_port);
        end
        mask_tbl[0] = 32'hFFFF_FFFF;
        send_ack = 1'b1;
        @(negedge clk);
        send_ack = 1'b0;
        n = 0;
        while (!send_req && n < 40) begin @(negedge clk); n++; end
        checks++;
        if ({send_req, send_dev, send_port} !== {1'b1, 2'd0, 5'd0}) begin
            errors++;
            $display("FAIL port_all: got req=%b dev=%0d port=%0d expected req=1 dev=0 port=0", send_req, send_dev, send_port);
        end
        enable = 1'b0;
        send_ack = 1'b1;
        @(negedge clk);
        send_ack = 1'b0;
    endtask

    // Transaction-level model: next device in rotation, request after each ready read, sweep after N empty reads.
    task automatic test_random();
        int exp_dev = 0, zc = 0, exp_next, exp_req_at = -1, exp_sweep = -1, seen, p_dev = 0, p_port = 0;
        bit req_on = 1'b0, ack_pend = 1'b0, new_rd;
        do_reset();
        rand_mode = 1'b1;
        enable = 1'b1;
        exp_next = cyc + 1;
        seen = rd_cnt;
        repeat (3000) begin
            @(negedge clk);
            if (ack_pend) begin req_on = 1'b0; ack_pend = 1'b0; exp_next = cyc; end
            if (cyc == exp_req_at) req_on = 1'b1;
            new_rd = (rd_cnt != seen);
            seen = rd_cnt;
            checks++;
            if (new_rd !== (cyc == exp_next)) begin
                errors++;
                $display("FAIL rand_read_time cyc %0d: got read=%b expected %b", cyc, new_rd, cyc == exp_next);
            end
            if (new_rd) begin
                checks++;
                if (state_addr !== addr_of(exp_dev)) begin
                    errors++;
                    $display("FAIL rand_addr cyc %0d: got %0h expected %0h", cyc, state_addr, addr_of(exp_dev));
                end
                if (last_rd_mask == '0) begin
                    zc++;
                    if (zc == N) begin zc = 0; exp_sweep = cyc + LAT + 1; end
                    exp_next = cyc + LAT + 1;
                end else begin
                    zc = 0;
                    exp_req_at = cyc + LAT + 1;
                    p_dev = exp_dev;
                    p_port = low_port(last_rd_mask);
                    exp_next = -1;
                end
                exp_dev = (exp_dev + 1) % N;
            end
            checks++;
            if (sweep_empty !== (cyc == exp_sweep)) begin
                errors++;
                $display("FAIL rand_sweep cyc %0d: got %b expected %b", cyc, sweep_empty, cyc == exp_sweep);
            end
            checks++;
            if (send_req !== req_on) begin
                errors++;
                $display("FAIL rand_req cyc %0d: got %b expected %b", cyc, send_req, req_on);
            end
            if (req_on) begin
                checks++;
                if ({send_dev, send_port} !== {DW'(p_dev), 5'(p_port)}) begin
                    errors++;
                    $display("FAIL rand_grant cyc %0d: got dev=%0d port=%0d expected dev=%0d port=%0d",
                             cyc, send_dev, send_port, p_dev, p_port);
                end
            end
            send_ack = ($urandom_range(0, 3) == 0);
            ack_pend = send_ack && req_on;
        end
        enable = 1'b0;
        send_ack = 1'b0;
        rand_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_empty_sweep();
        test_send_hold();
        test_fairness();
        test_enable_drop();
        test_async_reset();
        test_port_edges();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
